lsu_mem_ctrl: RTL and testbench

Load/store memory controller sitting directly downstream of the byte-write-enable decoder in the memory stage. Accepts one load or store per request, shifts the decoder's lane-0 write-enable pattern and store data onto the correct byte lanes, drives a single-port synchronous data RAM (1-cycle read latency), and returns sign- or zero-extended load data. Holds the pipeline via `stall` while an access is in flight.

---
 rtl/lsu_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: lane-shifts stores, drives a 1-cycle synchronous RAM, extends loads.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests trap instead of being force-aligned.
package lsu_mem_ctrl_pkg;
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;
endpackage

module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        alucode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we_in,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        is_load, is_store, is_byte, is_half;
    logic        accept, fault;
    logic [1:0]  off;
    logic        ld_q;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] raw, ext;
    logic        unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU: begin is_load = 1'b1;  is_byte = 1'b1; end
            ALU_LH, ALU_LHU: begin is_load = 1'b1;  is_half = 1'b1; end
            ALU_LW:          is_load = 1'b1;
            ALU_SB:          begin is_store = 1'b1; is_byte = 1'b1; end
            ALU_SH:          begin is_store = 1'b1; is_half = 1'b1; end
            ALU_SW:          is_store = 1'b1;
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready && (is_load || is_store);
    assign stall     = (state != IDLE) || accept;

    // Low address bits below the access size never reach the lane shifter.
    assign off = is_byte ? addr[1:0] : is_half ? {addr[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
    assign fault = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fault ? RESP : ACCESS;
            ACCESS:  state_nxt = ld_q ? WAIT : RESP;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign raw = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = raw;
        case (op_q)
            ALU_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            ALU_LBU: ext = {24'd0, raw[7:0]};
            ALU_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            ALU_LHU: ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // mem_en/mem_we/rsp_valid are single-cycle pulses; everything else holds until rewritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rdata     <= 32'd0;
            ld_q      <= 1'b0;
            op_q      <= 6'd0;
            off_q     <= 2'b00;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    ld_q     <= is_load;
                    op_q     <= alucode;
                    off_q    <= off;
                    mem_addr <= addr[ADDR_W+1:2];
                    if (fault) begin
                        rsp_valid <= 1'b1;
                        rdata     <= 32'd0;
                    end else begin
                        mem_en    <= 1'b1;
                        mem_we    <= is_store ? (we_in << off) : 4'b0000;
                        mem_wdata <= wdata << {off, 3'b000};
                    end
                end
                ACCESS: if (!ld_q) begin
                    rsp_valid <= 1'b1;
                    rdata     <= 32'd0;
                end
                WAIT: begin
                    rsp_valid <= 1'b1;
                    rdata     <= ext;
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= (state == IDLE) && accept && fault;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed spec scenarios plus random loads/stores against a byte-level memory model.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst, req_valid, req_ready, mem_en, rsp_valid, misalign, stall;
    logic [5:0]        alucode;
    logic [31:0]       addr, wdata, mem_wdata, mem_rdata, rdata;
    logic [3:0]        we_in, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              ram_clr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [5:0]  ops     [8];

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alucode(alucode), .addr(addr), .wdata(wdata), .we_in(we_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rdata(rdata),
        .misalign(misalign), .stall(stall)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_store(input logic [5:0] op);
        return op == ALU_SB || op == ALU_SH || op == ALU_SW;
    endfunction

    function automatic int size_of(input logic [5:0] op);
        if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 1;
        if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] eff_off(input logic [5:0] op, input logic [31:0] a);
        int sz = size_of(op);
        return 2'((int'(a[1:0]) / sz) * sz);
    endfunction

    function automatic bit is_mis(input logic [5:0] op, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (int'(a[1:0]) % size_of(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] dec_we(input logic [5:0] op);
        if (!is_store(op)) return 4'b0000;
        return 4'((1 << size_of(op)) - 1);
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] w = ref_mem[a[9:2]];
        int o = int'(eff_off(op, a));
        case (op)
            ALU_LB:  return 32'($signed(w[8*o +: 8]));
            ALU_LBU: return 32'(w[8*o +: 8]);
            ALU_LH:  return 32'($signed(w[8*o +: 16]));
            ALU_LHU: return 32'(w[8*o +: 16]);
            default: return w;
        endcase
    endfunction

    // One complete transaction with cycle-exact checks; returns at the first idle cycle.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  o   = eff_off(op, a);
        logic [31:0] exp = 32'd0;
        int          o_i = int'(o);
        @(negedge clk);
        req_valid = 1'b1; alucode = op; addr = a; wdata = wd; we_in = dec_we(op);
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("stall_accept", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (is_mis(op, a)) begin
            chk("trap_mem_en", 32'(mem_en), 32'd0);
            chk("trap_rsp", 32'(rsp_valid), 32'd1);
            chk("trap_misalign", 32'(misalign), 32'd1);
            chk("trap_rdata", rdata, 32'd0);
        end else begin
            chk("acc_mem_en", 32'(mem_en), 32'd1);
            chk("acc_mem_addr", 32'(mem_addr), 32'(a[9:2]));
            chk("acc_mem_we", 32'(mem_we), 32'(dec_we(op) << o));
            chk("acc_req_ready", 32'(req_ready), 32'd0);
            if (is_store(op)) begin
                chk("acc_mem_wdata", mem_wdata, wd << (8 * o_i));
                for (int k = 0; k < size_of(op); k++)
                    ref_mem[a[9:2]][8*(o_i+k) +: 8] = wd[8*k +: 8];
                @(negedge clk);
                chk("st_rsp", 32'(rsp_valid), 32'd1);
                chk("st_rdata", rdata, 32'd0);
                chk("st_misalign", 32'(misalign), 32'd0);
            end else begin
                exp = exp_load(op, a);
                @(negedge clk);
                chk("ld_wait_rsp", 32'(rsp_valid), 32'd0);
                chk("ld_wait_en", 32'(mem_en), 32'd0);
                @(negedge clk);
                chk("ld_rsp", 32'(rsp_valid), 32'd1);
                chk("ld_rdata", rdata, exp);
                chk("ld_misalign", 32'(misalign), 32'd0);
            end
        end
        @(negedge clk);
        chk("post_rsp", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        if (!is_store(op) && !is_mis(op, a)) chk("rdata_hold", rdata, exp);
    endtask

    initial begin
        logic [31:0] e1, e2, a;
        logic [5:0]  op;
        ops = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        rst = 1'b1; ram_clr = 1'b1; req_valid = 1'b0;
        alucode = 6'd0; addr = 32'd0; wdata = 32'd0; we_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0; ram_clr = 1'b0;

        // Directed scenarios
        do_op(ALU_SW, 32'h10, 32'hDEADBEEF);
        do_op(ALU_SB, 32'h13, 32'h000000A5);
        do_op(ALU_LB, 32'h13, 32'd0);
        chk("lb_0x13", rdata, 32'hFFFFFFA5);
        do_op(ALU_LBU, 32'h13, 32'd0);
        chk("lbu_0x13", rdata, 32'h000000A5);
        do_op(ALU_SH, 32'h22, 32'h00008001);
        do_op(ALU_LH, 32'h22, 32'd0);
        chk("lh_0x22", rdata, 32'hFFFF8001);
        do_op(ALU_LHU, 32'h22, 32'd0);
        chk("lhu_0x22", rdata, 32'h00008001);
        do_op(ALU_LW, 32'h11, 32'd0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_0x11_trap", rdata, 32'd0);
`else
        chk("lw_0x11_forced", rdata, 32'hA5ADBEEF);
`endif

        // Non-memory code is ignored
        @(negedge clk);
        req_valid = 1'b1; alucode = 6'd0; addr = 32'h10;
        #1 chk("nonmem_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("nonmem_en", 32'(mem_en), 32'd0);
        chk("nonmem_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Back-to-back loads with req_valid held high
        e1 = exp_load(ALU_LW, 32'h20);
        e2 = exp_load(ALU_LBU, 32'h13);
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_LW; addr = 32'h20; we_in = 4'd0;
        @(negedge clk);
        alucode = ALU_LBU; addr = 32'h13;
        #1;
        chk("b2b_en1", 32'(mem_en), 32'd1);
        chk("b2b_addr1", 32'(mem_addr), 32'd8);
        chk("b2b_stall1", 32'(stall), 32'd1);
        chk("b2b_ready1", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_stall2", 32'(stall), 32'd1);
        chk("b2b_ready2", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata1", rdata, e1);
        chk("b2b_stall3", 32'(stall), 32'd1);
        chk("b2b_ready3", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready4", 32'(req_ready), 32'd1);
        chk("b2b_stall4", 32'(stall), 32'd1);
        chk("b2b_en4", 32'(mem_en), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_en2", 32'(mem_en), 32'd1);
        chk("b2b_addr2", 32'(mem_addr), 32'd4);
        @(negedge clk);
        chk("b2b_rsp_gap", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata2", rdata, e2);
        @(negedge clk);

        // Reset in WAIT: response dropped
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_LW; addr = 32'h10; we_in = 4'd0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_en", 32'(mem_en), 32'd0);
        chk("rstw_rsp", 32'(rsp_valid), 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rstw_ready_after", 32'(req_ready), 32'd1);
        end

        // Reset in ACCESS of a store: write suppressed
        @(negedge clk);
        req_valid = 1'b1; alucode = ALU_SW; addr = 32'h10; wdata = 32'h12345678; we_in = 4'b1111;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rsta_en", 32'(mem_en), 32'd0);
        chk("rsta_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rsta_no_rsp", 32'(rsp_valid), 32'd0);
        do_op(ALU_LW, 32'h10, 32'd0);
        chk("rsta_word_kept", rdata, 32'hA5ADBEEF);

        // Random traffic over a small window, upper address bits randomised
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 7)];
            a  = 32'h40 + 32'($urandom_range(0, 15));
            a  = a | ($urandom & 32'hFFFF_FC00);
            do_op(op, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
